// File: rtl/sd_tx_sched.sv
// sd_tx_sched: turns decoded master commands into one-cycle slave status/data packet requests,
// with a post-message gap. Define SD_TX_SCHED_WDT_EN to add the message-end watchdog.
module sd_tx_sched #(
  parameter int GAP_CYCLES = 8,
  parameter int WDT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_s,
  input  logic       cmd_d,
  input  logic       rx_err_in,
  input  logic       sd_d_tx_rdy,
  input  logic       cd_busy,
  input  logic       msg_end,
  output logic       sd_s_req,
  output logic       sd_d_req,
  output logic       rx_err,
  output logic       sched_busy,
  output logic [7:0] drop_cnt,
  output logic       wdt_err,
  output logic [1:0] dbg_state_o
);

  // Handshake: cmd_s, cmd_d, rx_err_in, sd_s_req, sd_d_req and wdt_err are single-cycle pulses
  // with no back-pressure; cd_busy, sd_d_tx_rdy and msg_end are levels sampled every cycle.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic       pend_s_q, pend_s_d;
  logic       pend_d_q, pend_d_d;
  logic       s_req_q, s_req_d;
  logic       d_req_q, d_req_d;
  logic       rx_err_q, rx_err_d;
  logic       busy_q, busy_d;
  logic [7:0] drop_q, drop_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       drop_s_hit, drop_d_hit;
  logic [8:0] drop_sum;
  logic       grant;

`ifdef SD_TX_SCHED_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_err_q, wdt_err_d;
`endif

  // A command landing in the grant cycle starts a fresh pending request, so it is not a drop.
  always_comb begin
    drop_s_hit = cmd_s & pend_s_q & (state_q != ST_ISSUE);
    drop_d_hit = cmd_d & pend_d_q & (state_q != ST_ISSUE);
    drop_sum   = {1'b0, drop_q} + {8'd0, drop_s_hit} + {8'd0, drop_d_hit};
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Set wins over clear so an error seen alongside a request is reported with the next one.
  assign rx_err_d = rx_err_in | (rx_err_q & ~(s_req_q | d_req_q));

  assign grant = pend_s_q | pend_d_q;

  always_comb begin
    state_d   = state_q;
    pend_s_d  = pend_s_q | cmd_s;
    pend_d_d  = pend_d_q | cmd_d;
    s_req_d   = 1'b0;
    d_req_d   = 1'b0;
    gap_cnt_d = gap_cnt_q;
`ifdef SD_TX_SCHED_WDT_EN
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((pend_s_d | pend_d_d) && !cd_busy) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (grant) begin
          if (pend_d_q && sd_d_tx_rdy) begin
            d_req_d = 1'b1;
          end else begin
            s_req_d = 1'b1;
          end
          pend_s_d = cmd_s;
          pend_d_d = cmd_d;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef SD_TX_SCHED_WDT_EN
        wdt_cnt_d = 16'd0;
`endif
      end
      ST_WAIT: begin
        if (msg_end) begin
          state_d   = ST_GAP;
          gap_cnt_d = 8'd0;
        end
`ifdef SD_TX_SCHED_WDT_EN
        else if (wdt_cnt_q == WDT_LAST) begin
          state_d   = ST_GAP;
          gap_cnt_d = 8'd0;
          wdt_err_d = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 16'd1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_s_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      s_req_q   <= 1'b0;
      d_req_q   <= 1'b0;
      rx_err_q  <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 8'd0;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      pend_s_q  <= pend_s_d;
      pend_d_q  <= pend_d_d;
      s_req_q   <= s_req_d;
      d_req_q   <= d_req_d;
      rx_err_q  <= rx_err_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef SD_TX_SCHED_WDT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q <= 16'd0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
    end
  end
  assign wdt_err = wdt_err_q;
`else
  assign wdt_err = 1'b0;
`endif

  assign sd_s_req    = s_req_q;
  assign sd_d_req    = d_req_q;
  assign rx_err      = rx_err_q;
  assign sched_busy  = busy_q;
  assign drop_cnt    = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_tx_sched.sv
// tb_sd_tx_sched: directed steps plus random traffic against a cycle-level reference model of
// the scheduler rules; set SD_TX_SCHED_WDT_EN to match the design build.
module tb_sd_tx_sched;

  localparam int GAP = 8;
  localparam int WDT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_s = 1'b0, cmd_d = 1'b0, rx_err_in = 1'b0;
  logic       sd_d_tx_rdy = 1'b0, cd_busy = 1'b0, msg_end = 1'b0;
  logic       sd_s_req, sd_d_req, rx_err, sched_busy, wdt_err;
  logic [7:0] drop_cnt;
  logic [1:0] dbg_state_o;

  int total = 0;
  int bad   = 0;

  sd_tx_sched #(.GAP_CYCLES(GAP), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .cmd_s(cmd_s), .cmd_d(cmd_d), .rx_err_in(rx_err_in),
    .sd_d_tx_rdy(sd_d_tx_rdy), .cd_busy(cd_busy), .msg_end(msg_end),
    .sd_s_req(sd_s_req), .sd_d_req(sd_d_req), .rx_err(rx_err), .sched_busy(sched_busy),
    .drop_cnt(drop_cnt), .wdt_err(wdt_err), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus countdown timers; outputs predicted for the cycle after each edge.
  typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_GAP} ph_t;
  ph_t m_ph = M_IDLE;
  bit  m_pend_s, m_pend_d, m_s_req, m_d_req, m_rx, m_wdt, m_busy;
  int  m_drop, m_gap_left, m_wdt_left;

  task automatic model_step(input bit r, input bit cs, input bit cd, input bit rxi,
                            input bit rdy, input bit busy, input bit me);
    bit  was_req = m_s_req | m_d_req;
    int  drops = 0;
    ph_t nph = m_ph;
    if (r) begin
      m_ph = M_IDLE; m_pend_s = 0; m_pend_d = 0; m_s_req = 0; m_d_req = 0;
      m_rx = 0; m_wdt = 0; m_busy = 0; m_drop = 0; m_gap_left = 0; m_wdt_left = 0;
      return;
    end
    m_s_req = 0; m_d_req = 0; m_wdt = 0;
    if (m_ph != M_ISSUE) drops = int'(cs && m_pend_s) + int'(cd && m_pend_d);
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_rx = rxi || (m_rx && !was_req);
    case (m_ph)
      M_IDLE: begin
        m_pend_s |= cs; m_pend_d |= cd;
        if ((m_pend_s || m_pend_d) && !busy) nph = M_ISSUE;
      end
      M_ISSUE: begin
        if (m_pend_d && rdy) m_d_req = 1;
        else m_s_req = 1;
        m_pend_s = cs; m_pend_d = cd;
        nph = M_WAIT; m_wdt_left = WDT;
      end
      M_WAIT: begin
        m_pend_s |= cs; m_pend_d |= cd;
        if (me) begin
          nph = M_GAP; m_gap_left = GAP;
        end
`ifdef SD_TX_SCHED_WDT_EN
        else begin
          m_wdt_left--;
          if (m_wdt_left == 0) begin
            m_wdt = 1; nph = M_GAP; m_gap_left = GAP;
          end
        end
`endif
      end
      M_GAP: begin
        m_pend_s |= cs; m_pend_d |= cd;
        m_gap_left--;
        if (m_gap_left == 0) nph = M_IDLE;
      end
      default: nph = M_IDLE;
    endcase
    m_ph = nph;
    m_busy = (nph != M_IDLE);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("m_s_req", 16'(sd_s_req), 16'(m_s_req));
    chk("m_d_req", 16'(sd_d_req), 16'(m_d_req));
    chk("m_rx_err", 16'(rx_err), 16'(m_rx));
    chk("m_busy", 16'(sched_busy), 16'(m_busy));
    chk("m_drop", 16'(drop_cnt), 16'(m_drop));
    chk("m_wdt", 16'(wdt_err), 16'(m_wdt));
  endtask

  task automatic tick();
    model_step(rst, cmd_s, cmd_d, rx_err_in, sd_d_tx_rdy, cd_busy, msg_end);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_cmd(input bit s, input bit d);
    cmd_s = s; cmd_d = d;
    tick();
    cmd_s = 0; cmd_d = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic finish_msg();
    msg_end = 1; tick(); msg_end = 0;
    ticks(GAP);
    chk("idle_after_gap", 16'(sched_busy), 16'd0);
  endtask

  initial begin
    int ns, nd;
    // Reset overrides active inputs.
    cmd_s = 1; cmd_d = 1; rx_err_in = 1; msg_end = 1;
    tick(); tick();
    chk("rst_s_req", 16'(sd_s_req), 16'd0);
    chk("rst_d_req", 16'(sd_d_req), 16'd0);
    chk("rst_rx_err", 16'(rx_err), 16'd0);
    chk("rst_busy", 16'(sched_busy), 16'd0);
    chk("rst_drop", 16'(drop_cnt), 16'd0);
    chk("rst_state", 16'(dbg_state_o), 16'd0);
    cmd_s = 0; cmd_d = 0; rx_err_in = 0; msg_end = 0; rst = 0;

    // Status request latency, msg_end ignored outside WAIT_END, gap length.
    ticks(3);
    msg_end = 1; tick(); msg_end = 0;
    chk("me_idle_ignored", 16'(sched_busy), 16'd0);
    pulse_cmd(1, 0);                                   // cycle N -> now N+1
    chk("lat_n1_req", 16'(sd_s_req), 16'd0);
    chk("lat_n1_state", 16'(dbg_state_o), 16'd1);
    msg_end = 1; tick(); msg_end = 0;                  // N+2
    chk("lat_n2_s_req", 16'(sd_s_req), 16'd1);
    chk("lat_n2_d_req", 16'(sd_d_req), 16'd0);
    tick();                                            // N+3
    chk("lat_n3_s_req", 16'(sd_s_req), 16'd0);
    chk("me_issue_ignored", 16'(dbg_state_o), 16'd2);
    ticks(7);                                          // N+10
    msg_end = 1; tick(); msg_end = 0;                  // N+11 first GAP cycle
    chk("gap_first", 16'(dbg_state_o), 16'd3);
    ticks(GAP - 1);
    chk("gap_last_busy", 16'(sched_busy), 16'd1);
    tick();
    chk("gap_done_busy", 16'(sched_busy), 16'd0);
    chk("gap_done_state", 16'(dbg_state_o), 16'd0);

    // Data request arbitration.
    sd_d_tx_rdy = 1; pulse_cmd(0, 1); tick();
    chk("d_rdy_d_req", 16'(sd_d_req), 16'd1);
    chk("d_rdy_s_req", 16'(sd_s_req), 16'd0);
    finish_msg();
    sd_d_tx_rdy = 0; pulse_cmd(0, 1); tick();
    chk("d_nrdy_s_req", 16'(sd_s_req), 16'd1);
    chk("d_nrdy_d_req", 16'(sd_d_req), 16'd0);
    finish_msg();
    sd_d_tx_rdy = 1; pulse_cmd(1, 1); tick();
    chk("both_d_req", 16'(sd_d_req), 16'd1);
    chk("both_s_req", 16'(sd_s_req), 16'd0);
    finish_msg();
    ticks(3);
    chk("both_cleared", 16'(sched_busy), 16'd0);

    // Drops during WAIT_END, then a single follow-up request.
    sd_d_tx_rdy = 0;
    pulse_cmd(1, 0); tick();
    pulse_cmd(1, 0); tick(); pulse_cmd(1, 0); tick(); pulse_cmd(1, 0);
    chk("drop_two", 16'(drop_cnt), 16'd2);
    finish_msg();
    ns = 0; nd = 0;
    repeat (4) begin
      tick(); ns += int'(sd_s_req); nd += int'(sd_d_req);
    end
    chk("followup_s_cnt", 16'(ns), 16'd1);
    chk("followup_d_cnt", 16'(nd), 16'd0);
    finish_msg();
    cmd_s = 1; ticks(320); cmd_s = 0;
    chk("drop_sat", 16'(drop_cnt), 16'd255);
    do_reset();
    chk("drop_rst", 16'(drop_cnt), 16'd0);

    // Sticky rx_err.
    rx_err_in = 1; tick(); rx_err_in = 0;
    chk("rx_set", 16'(rx_err), 16'd1);
    ticks(3);
    chk("rx_hold", 16'(rx_err), 16'd1);
    pulse_cmd(1, 0); tick();
    chk("rx_with_req", 16'(rx_err), 16'd1);
    tick();
    chk("rx_cleared", 16'(rx_err), 16'd0);
    finish_msg();
    pulse_cmd(1, 0); tick();
    rx_err_in = 1; tick(); rx_err_in = 0;
    chk("rx_coincident", 16'(rx_err), 16'd1);
    tick();
    chk("rx_coincident_hold", 16'(rx_err), 16'd1);
    finish_msg();

    // Watchdog on a message that never ends.
    pulse_cmd(1, 0); tick(); ticks(WDT - 1);
    chk("wdt_early", 16'(wdt_err), 16'd0);
    tick();
`ifdef SD_TX_SCHED_WDT_EN
    chk("wdt_pulse", 16'(wdt_err), 16'd1);
    chk("wdt_to_gap", 16'(dbg_state_o), 16'd3);
    tick();
    chk("wdt_one_cycle", 16'(wdt_err), 16'd0);
`else
    chk("wdt_off", 16'(wdt_err), 16'd0);
    chk("wdt_off_wait", 16'(dbg_state_o), 16'd2);
`endif

    // Reset mid-message with cd_busy held.
    do_reset();
    pulse_cmd(1, 0); tick(); ticks(2);
    cd_busy = 1; rst = 1; cmd_s = 1; tick(); rst = 0; cmd_s = 0;
    chk("midrst_busy", 16'(sched_busy), 16'd0);
    chk("midrst_state", 16'(dbg_state_o), 16'd0);
    tick();
    chk("midrst_no_req", 16'(sd_s_req | sd_d_req), 16'd0);
    chk("midrst_no_wdt", 16'(wdt_err), 16'd0);
    pulse_cmd(1, 0); ticks(4);
    chk("cdbusy_hold", 16'(sched_busy), 16'd0);
    cd_busy = 0; tick();
    chk("cdbusy_issue", 16'(dbg_state_o), 16'd1);
    tick();
    chk("cdbusy_req", 16'(sd_s_req), 16'd1);
    finish_msg();

    // Random traffic: sparse then dense commands.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int dense = (i >= 2000) ? 1 : 0;
      rst         = ($urandom_range(0, 299) == 0);
      cmd_s       = dense ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      cmd_d       = dense ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
      rx_err_in   = ($urandom_range(0, 19) == 0);
      sd_d_tx_rdy = ($urandom_range(0, 1) == 0);
      cd_busy     = ($urandom_range(0, 3) == 0);
      msg_end     = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 0; cmd_s = 0; cmd_d = 0; rx_err_in = 0; cd_busy = 0; msg_end = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_tx_sched.md
SD_TX_SCHED -- requirements
Module: sd_tx_sched

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 8: idle cycles enforced between end of one slave message and next request; range 1..255.
REQ-002 SHALL have parameter WDT_CYCLES, default 4096: cycles allowed in WAIT_END before abort; range 2..65535.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_s  in  1  one-cycle pulse: master status request decoded.
REQ-006 SHALL have port cmd_d  in  1  one-cycle pulse: master data request decoded.
REQ-007 SHALL have port rx_err_in  in  1  one-cycle pulse: receive error detected.
REQ-008 SHALL have port sd_d_tx_rdy  in  1  level: slave payload frame available.
REQ-009 SHALL have port cd_busy  in  1  level: coder busy.
REQ-010 SHALL have port msg_end  in  1  level: slave packet controller message end.
REQ-011 SHALL have port sd_s_req  out  1  one-cycle status-packet request.
REQ-012 SHALL have port sd_d_req  out  1  one-cycle data-packet request.
REQ-013 SHALL have port rx_err  out  1  sticky receive-error flag for the packet controller.
REQ-014 SHALL have port sched_busy  out  1  high in any state except IDLE.
REQ-015 SHALL have port drop_cnt  out  8  saturating count of dropped commands.
REQ-016 SHALL have port wdt_err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-017 SHALL latch cmd_s into pend_s and cmd_d into pend_d in any state; simultaneous cmd_s and cmd_d SHALL set both.
REQ-018 SHALL increment drop_cnt (saturate at 255) when a command arrives while its pend flag is already set; two drops in one cycle SHALL add 2, still saturating.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_END, GAP; all outputs registered.
REQ-020 IDLE -> ISSUE when (pend_s | pend_d) and cd_busy=0; evaluation uses flags including same-cycle commands.
REQ-021 ISSUE (exactly one cycle): pend_d & sd_d_tx_rdy -> sd_d_req=1; pend_d & ~sd_d_tx_rdy -> sd_s_req=1; else pend_s -> sd_s_req=1; never both asserted.
REQ-022 On any grant in ISSUE SHALL clear pend_s and pend_d (the data or status reply carries status); a command arriving in the ISSUE cycle SHALL remain pending.
REQ-023 Latency: cmd pulse at cycle N in IDLE with cd_busy=0, nothing pending -> request asserted in cycle N+2 (IDLE->ISSUE registered, request in ISSUE).
REQ-024 ISSUE -> WAIT_END; WAIT_END -> GAP on first cycle msg_end=1, ignoring msg_end in the ISSUE cycle.
REQ-025 GAP SHALL count GAP_CYCLES cycles then return to IDLE; pending commands wait.
REQ-026 rx_err SHALL set on rx_err_in, clear the cycle after a request is issued; rx_err_in coincident with the issue cycle SHALL leave rx_err=1.
REQ-027 msg_end outside WAIT_END SHALL be ignored.

Reset
REQ-028 rst=1 SHALL force state IDLE, pend_s=pend_d=0, sd_s_req=sd_d_req=0, rx_err=0, sched_busy=0, drop_cnt=0, wdt_err=0, counters=0, overriding same-cycle inputs.
REQ-029 Reset mid-message SHALL abandon it silently; no wdt_err, no request in the following cycle.

Configuration
REQ-030 Macro SD_TX_SCHED_WDT_EN defined: WAIT_END counter; after WDT_CYCLES cycles without msg_end SHALL pulse wdt_err one cycle and go to GAP.
REQ-031 Macro SD_TX_SCHED_WDT_EN undefined: no watchdog counter, wdt_err tied 0, WAIT_END held until msg_end.

Verification
REQ-032 cmd_s at cycle 10, cd_busy=0 -> sd_s_req=1 at cycle 12 only; msg_end at 20 -> GAP 21..28, IDLE at 29.
REQ-033 cmd_d with sd_d_tx_rdy=1 -> sd_d_req one cycle; with sd_d_tx_rdy=0 -> sd_s_req instead; both cmd pulses same cycle -> single sd_d_req, both pends cleared.
REQ-034 Three cmd_s during WAIT_END -> drop_cnt=2, one sd_s_req after GAP; 300 drops -> drop_cnt=255.
REQ-035 rx_err_in pulse in IDLE -> rx_err=1 until cycle after next request; rx_err_in in issue cycle -> rx_err stays 1.
REQ-036 WDT_EN, WDT_CYCLES=16, no msg_end -> wdt_err pulse after 16 WAIT_END cycles, then GAP; without macro -> waits, wdt_err=0.
REQ-037 rst in WAIT_END and cd_busy=1 held after -> all outputs 0, pending cmd issued only once cd_busy=0.
